// File: rtl/alu_decoder_pkg.sv
// alu_decoder_pkg
//   Shared definitions for the ALU decoder slice: RV32I opcode constants,
//   alu_op_select codes, result-source (mux2) codes and the decoded-bundle
//   struct carried from the combinational decoder to the output register.
//   mux2_of() maps an operation code to the ALU result source.
package alu_decoder_pkg;

    localparam int XLEN = 32;

    // RV32I major opcodes (instr[6:0], low two bits included)
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // alu_op_select codes; 1110 and 1111 are never produced
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_EQ   = 4'b1010;
    localparam logic [3:0] ALU_NE   = 4'b1011;
    localparam logic [3:0] ALU_GE   = 4'b1100;
    localparam logic [3:0] ALU_GEU  = 4'b1101;

    // ALU result source (alu_mux2_select)
    localparam logic [1:0] MUX2_ADDER   = 2'b00;
    localparam logic [1:0] MUX2_LOGIC   = 2'b01;
    localparam logic [1:0] MUX2_SHIFT   = 2'b10;
    localparam logic [1:0] MUX2_COMPARE = 2'b11;

    typedef struct packed {
        logic [XLEN-1:0] opd1;
        logic [XLEN-1:0] opd2;
        logic [XLEN-1:0] opd3;
        logic [XLEN-1:0] opd4;
        logic            mux1_sel;
        logic [1:0]      mux2_sel;
        logic [3:0]      op_sel;
        logic            is_branch;
        logic            illegal;
    } alu_bundle_t;

    function automatic logic [1:0] mux2_of(input logic [3:0] op);
        case (op)
            ALU_ADD, ALU_SUB:          mux2_of = MUX2_ADDER;
            ALU_AND, ALU_OR, ALU_XOR:  mux2_of = MUX2_LOGIC;
            ALU_SLL, ALU_SRL, ALU_SRA: mux2_of = MUX2_SHIFT;
            default:                   mux2_of = MUX2_COMPARE;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// alu_decode_comb
//   Purely combinational RV32I -> ALU field decoder.
//   Ports:
//     instr     in   instruction word
//     pc        in   instruction address
//     rs1_data  in   register rs1 value
//     rs2_data  in   register rs2 value
//     bundle    out  decoded operands, selects and flags
module alu_decode_comb
    import alu_decoder_pkg::*;
(
    input  logic [31:0]   instr,
    input  logic [31:0]   pc,
    input  logic [31:0]   rs1_data,
    input  logic [31:0]   rs2_data,
    output alu_bundle_t   bundle
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_b;
    logic [31:0] shamt;
    logic        bad;
    logic        unused_rs1_index;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign shamt  = {27'b0, instr[24:20]};
    // Register indices are resolved upstream; only the data arrives here.
    assign unused_rs1_index = ^instr[19:15];

    always_comb begin
        bundle = '0;
        bad    = 1'b0;
        case (opcode)
            OPC_OP: begin
                bundle.opd1 = rs1_data;
                bundle.opd2 = rs2_data;
                // funct7=0x20 is only meaningful for SUB and SRA
                bad = !((funct7 == 7'h00) ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
                case (funct3)
                    3'b000:  bundle.op_sel = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  bundle.op_sel = ALU_SLL;
                    3'b010:  bundle.op_sel = ALU_SLT;
                    3'b011:  bundle.op_sel = ALU_SLTU;
                    3'b100:  bundle.op_sel = ALU_XOR;
                    3'b101:  bundle.op_sel = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  bundle.op_sel = ALU_OR;
                    default: bundle.op_sel = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                bundle.opd1 = rs1_data;
                bundle.opd2 = imm_i;
                case (funct3)
                    3'b000:  bundle.op_sel = ALU_ADD;
                    3'b001: begin
                        bundle.opd2   = shamt;
                        bundle.op_sel = ALU_SLL;
                        bad           = (funct7 != 7'h00);
                    end
                    3'b010:  bundle.op_sel = ALU_SLT;
                    3'b011:  bundle.op_sel = ALU_SLTU;
                    3'b100:  bundle.op_sel = ALU_XOR;
                    3'b101: begin
                        bundle.opd2   = shamt;
                        bundle.op_sel = funct7[5] ? ALU_SRA : ALU_SRL;
                        bad           = (funct7 != 7'h00) && (funct7 != 7'h20);
                    end
                    3'b110:  bundle.op_sel = ALU_OR;
                    default: bundle.op_sel = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                bundle.opd2 = imm_u;
            end
            OPC_AUIPC: begin
                bundle.opd1 = pc;
                bundle.opd2 = imm_u;
            end
            OPC_BRANCH: begin
                // Adder forms the target; comparator works on opd3/opd4
                bundle.opd1      = pc;
                bundle.opd2      = imm_b;
                bundle.opd3      = rs1_data;
                bundle.opd4      = rs2_data;
                bundle.mux1_sel  = 1'b1;
                bundle.is_branch = 1'b1;
                case (funct3)
                    3'b000:  bundle.op_sel = ALU_EQ;
                    3'b001:  bundle.op_sel = ALU_NE;
                    3'b100:  bundle.op_sel = ALU_SLT;
                    3'b101:  bundle.op_sel = ALU_GE;
                    3'b110:  bundle.op_sel = ALU_SLTU;
                    3'b111:  bundle.op_sel = ALU_GEU;
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase

        // Branch results come from the adder (target); compare is side-band
        if (!bundle.is_branch) begin
            bundle.mux2_sel = mux2_of(bundle.op_sel);
        end

        if (bad) begin
            bundle         = '0;
            bundle.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_decoder.sv
// alu_decoder
//   Decodes one RV32I instruction bundle per valid/ready transfer into ALU
//   operands and selects, registered toward the execute stage.
//   Handshake: a transfer happens on a rising edge where valid && ready;
//   out_* is held stable while out_valid && !out_ready; an accepted bundle
//   appears on out_* one cycle later.
//   Build option ALU_DEC_SKID_EN: adds a skid entry so in_ready becomes a
//   pure register output (no path from out_ready). Without it, a single
//   output register with in_ready = !out_valid || out_ready.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready        input bundle handshake
//     instr, pc, rs1_data, rs2_data   input bundle
//     out_valid/out_ready      output bundle handshake
//     opd1..opd4               ALU operands
//     alu_mux1_select          comparison source (1 = opd3/opd4)
//     alu_mux2_select          result source
//     alu_op_select            operation code
//     is_branch, illegal       bundle flags
module alu_decoder
    import alu_decoder_pkg::*;
#(
    parameter int OPERAND_LENGTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               instr,
    input  logic [OPERAND_LENGTH-1:0] pc,
    input  logic [OPERAND_LENGTH-1:0] rs1_data,
    input  logic [OPERAND_LENGTH-1:0] rs2_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPERAND_LENGTH-1:0] opd1,
    output logic [OPERAND_LENGTH-1:0] opd2,
    output logic [OPERAND_LENGTH-1:0] opd3,
    output logic [OPERAND_LENGTH-1:0] opd4,
    output logic                      alu_mux1_select,
    output logic [1:0]                alu_mux2_select,
    output logic [3:0]                alu_op_select,
    output logic                      is_branch,
    output logic                      illegal
);

    alu_bundle_t dec;
    alu_bundle_t out_q;
    logic        out_valid_q;

    alu_decode_comb u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .bundle   (dec)
    );

`ifdef ALU_DEC_SKID_EN
    alu_bundle_t skid_q;
    logic        skid_valid_q;
    logic        accept;
    logic        out_free;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && !skid_valid_q;
    assign out_free = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so nothing new arrives while draining
            if (out_free) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end
        end else if (accept) begin
            if (out_free) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                // Output stalled in the same cycle we accepted: park it
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid       = out_valid_q;
    assign opd1            = out_q.opd1;
    assign opd2            = out_q.opd2;
    assign opd3            = out_q.opd3;
    assign opd4            = out_q.opd4;
    assign alu_mux1_select = out_q.mux1_sel;
    assign alu_mux2_select = out_q.mux2_sel;
    assign alu_op_select   = out_q.op_sel;
    assign is_branch       = out_q.is_branch;
    assign illegal         = out_q.illegal;

endmodule

// File: tb/tb_alu_decoder.sv
// tb_alu_decoder
//   Randomized scoreboard bench for alu_decoder. Expected bundles come from
//   hand-written constants (directed cases) or a mnemonic-level reference
//   model; a negedge monitor pops and compares on every output transfer.
module tb_alu_decoder;

    typedef logic [136:0] vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] opd1, opd2, opd3, opd4;
    logic        alu_mux1_select;
    logic [1:0]  alu_mux2_select;
    logic [3:0]  alu_op_select;
    logic        is_branch;
    logic        illegal;

    vec_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          tog_en = 1'b0;
    logic        ir_before;
    vec_t        act;

    alu_decoder #(.OPERAND_LENGTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .instr           (instr),
        .pc              (pc),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .opd1            (opd1),
        .opd2            (opd2),
        .opd3            (opd3),
        .opd4            (opd4),
        .alu_mux1_select (alu_mux1_select),
        .alu_mux2_select (alu_mux2_select),
        .alu_op_select   (alu_op_select),
        .is_branch       (is_branch),
        .illegal         (illegal)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    assign act = {opd1, opd2, opd3, opd4, alu_mux1_select, alu_mux2_select,
                  alu_op_select, is_branch, illegal};

    // ---------------- helpers ----------------
    function automatic vec_t pack(input logic [31:0] o1, o2, o3, o4,
                                  input logic m1, input logic [1:0] m2,
                                  input logic [3:0] op, input logic br, il);
        return {o1, o2, o3, o4, m1, m2, op, br, il};
    endfunction

    task automatic check(input string name, input vec_t a, input vec_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, a, e);
        end
    endtask

    // Reference model: works from mnemonic tables and integer immediates
    function automatic vec_t ref_model(input logic [31:0] ins, p, a, b);
        int          opc, f3, f7, op, m2, imm_i, imm_b, shamt;
        int          rop[8];
        int          bop[8];
        logic [31:0] imm_u, x1, x2, x3, x4;
        logic [3:0]  op4;
        logic [1:0]  m2b;
        bit          m1, br;
        // OP/OP-IMM funct3 -> ADD SLL SLT SLTU XOR SRL OR AND
        rop = '{0, 5, 8, 9, 4, 6, 3, 2};
        // BRANCH funct3 -> EQ NE - - SLT GE SLTU GEU
        bop = '{10, 11, -1, -1, 8, 12, 9, 13};
        opc   = int'(ins & 32'h7f);
        f3    = int'((ins >> 12) & 32'h7);
        f7    = int'(ins >> 25);
        imm_i = $signed(ins) >>> 20;
        imm_u = ins & 32'hFFFF_F000;
        imm_b = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
              + int'((ins >> 25) & 32'h3f) * 32 + int'((ins >> 8) & 32'hf) * 2;
        shamt = int'((ins >> 20) & 32'h1f);
        op = -1; x1 = 0; x2 = 0; x3 = 0; x4 = 0; m1 = 0; br = 0;
        case (opc)
            'h33: begin
                x1 = a; x2 = b;
                if (f7 == 0) op = rop[f3];
                else if (f7 == 32 && f3 == 0) op = 1;
                else if (f7 == 32 && f3 == 5) op = 7;
            end
            'h13: begin
                x1 = a; x2 = imm_i;
                if (f3 == 1) begin
                    x2 = shamt;
                    if (f7 == 0) op = 5;
                end else if (f3 == 5) begin
                    x2 = shamt;
                    if (f7 == 0) op = 6;
                    else if (f7 == 32) op = 7;
                end else op = rop[f3];
            end
            'h37: begin x2 = imm_u; op = 0; end
            'h17: begin x1 = p; x2 = imm_u; op = 0; end
            'h63: begin
                x1 = p; x2 = imm_b; x3 = a; x4 = b; m1 = 1; br = 1;
                op = bop[f3];
            end
            default: op = -1;
        endcase
        if (op < 0) return pack(0, 0, 0, 0, 0, 2'd0, 4'd0, 0, 1);
        if (br)          m2 = 0;
        else if (op <= 1) m2 = 0;
        else if (op <= 4) m2 = 1;
        else if (op <= 7) m2 = 2;
        else              m2 = 3;
        op4 = op[3:0];
        m2b = m2[1:0];
        return pack(x1, x2, x3, x4, m1, m2b, op4, br, 0);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7sel;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case ($urandom_range(0, 2))
            0:       f7sel = 7'h00;
            1:       f7sel = 7'h20;
            default: f7sel = r[31:25];
        endcase
        case (k)
            0, 1, 2: return {f7sel, r[24:7], 7'h33};
            3, 4, 5: return {f7sel, r[24:7], 7'h13};
            6:       return {r[31:7], 7'h37};
            7:       return {r[31:7], 7'h17};
            8:       return {r[31:7], 7'h63};
            default: return r;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Entered just after a rising edge; leaves just after the edge that took the bundle.
    task automatic send(input logic [31:0] ins, p, a, b, input vec_t e);
        int waitc;
        waitc = 0;
        instr = ins; pc = p; rs1_data = a; rs2_data = b; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                break;
            end
            waitc++;
            if (waitc > 50) begin
                total++; bad++;
                $display("FAIL accept_timeout act=in_ready_low exp=accept_within_50");
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Random out_ready; with the skid build in_ready must ignore it within a cycle
    always @(posedge clk) begin
        #1;
        if (tog_en) begin
            ir_before = in_ready;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
`ifdef ALU_DEC_SKID_EN
            check("in_ready_reg", vec_t'(in_ready), vec_t'(ir_before));
`endif
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
`ifndef ALU_DEC_SKID_EN
            check("in_ready_comb", vec_t'(in_ready), vec_t'(!out_valid || out_ready));
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_bundle act=%h exp=none", act);
                end else begin
                    check("bundle", act, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ins, p, a, b;
        int          waitc;

        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", vec_t'(out_valid), vec_t'(0));
        check("reset_in_ready", vec_t'(in_ready), vec_t'(1));
        check("reset_data", act, vec_t'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // directed cases, out_ready held high
        send(32'h002081B3, 32'h0, 32'd5, 32'd7,
             pack(32'd5, 32'd7, 0, 0, 0, 2'b00, 4'b0000, 0, 0));
        check("latency_1", vec_t'(out_valid), vec_t'(1));
        ins = {7'h20, 5'd4, 5'd1, 3'b101, 5'd2, 7'h13};
        send(ins, 32'h0, 32'hF000_0000, 32'd0,
             pack(32'hF000_0000, 32'd4, 0, 0, 0, 2'b10, 4'b0111, 0, 0));
        ins = {7'h10, 5'd4, 5'd1, 3'b101, 5'd2, 7'h13};
        send(ins, 32'h0, 32'hF000_0000, 32'd0,
             pack(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 1));
        ins = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b110, 4'b1100, 1'b1, 7'h63};
        send(ins, 32'h100, 32'd3, 32'd9,
             pack(32'h100, 32'hFFFF_FFF8, 32'd3, 32'd9, 1, 2'b00, 4'b1001, 1, 0));
        ins = {20'h12345, 5'd1, 7'h17};
        send(ins, 32'h40, 32'd1, 32'd2,
             pack(32'h40, 32'h1234_5000, 0, 0, 0, 2'b00, 4'b0000, 0, 0));
        ins = 32'h0000_0000;   // instr[1:0] != 11
        send(ins, 32'h8, 32'd1, 32'd2,
             pack(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 1));

        // random stream with random output back-pressure
        tog_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ins = rand_instr(); p = $urandom; a = $urandom; b = $urandom;
            send(ins, p, a, b, ref_model(ins, p, a, b));
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        tog_en = 1'b0;
        @(posedge clk); #3;
        out_ready = 1'b1;
        waitc = 0;
        while (exp_q.size() != 0 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("drain_empty", vec_t'(exp_q.size()), vec_t'(0));

        // reset while stalled: buffered bundles must vanish
        out_ready = 1'b0;
        ins = 32'h002081B3;
        send(ins, 32'h0, 32'd11, 32'd22, ref_model(ins, 32'h0, 32'd11, 32'd22));
        check("stall_valid", vec_t'(out_valid), vec_t'(1));
        instr = {7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_stall_out_valid", vec_t'(out_valid), vec_t'(0));
        check("rst_stall_in_ready", vec_t'(in_ready), vec_t'(1));
        exp_q.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_idle", vec_t'(out_valid), vec_t'(0));

        // recovery stream
        for (int i = 0; i < 8; i++) begin
            ins = rand_instr(); p = $urandom; a = $urandom; b = $urandom;
            send(ins, p, a, b, ref_model(ins, p, a, b));
        end
        in_valid = 1'b0;
        waitc = 0;
        while (exp_q.size() != 0 && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("final_drain_empty", vec_t'(exp_q.size()), vec_t'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
